// File: rtl/food_spawner.sv
// food_spawner
//   Places a new food item on the playfield. Draws candidate cells from the
//   free-running random generator and drops any that fall off the grid. It
//   checks each remaining candidate against the snake body through a
//   one-outstanding req/ack query port, then publishes the first free cell.
//
// Optional feature macro: FOOD_SCAN_FALLBACK_EN
//   When defined, running out of random attempts starts a raster scan from
//   (0,0) instead of failing immediately.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   randX, randY        random candidate coordinates, new every cycle
//   spawn_req           one-cycle spawn request (accepted only when idle)
//   occ_x, occ_y        coordinate under query, held until acknowledged
//   occ_req             one-cycle query strobe
//   occ_ack, occ_hit    query answer; hit=1 means the cell holds snake
//   food_x, food_y      current food position
//   food_valid          food position is live
//   spawn_done          one-cycle pulse, food placed
//   spawn_fail          one-cycle pulse, no free cell found
//   busy                high whenever the spawner is not idle
module food_spawner #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] randX,
    input  logic [6:0] randY,
    input  logic       spawn_req,
    output logic [6:0] occ_x,
    output logic [6:0] occ_y,
    output logic       occ_req,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [6:0] food_x,
    output logic [6:0] food_y,
    output logic       food_valid,
    output logic       spawn_done,
    output logic       spawn_fail,
    output logic       busy
);

`ifdef FOOD_SCAN_FALLBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_CHECK, S_SCAN, S_SCAN_WAIT, S_DONE, S_FAIL
    } state_t;
    localparam state_t S_EXH = S_SCAN;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_CHECK, S_DONE, S_FAIL
    } state_t;
    localparam state_t S_EXH = S_FAIL;
`endif

    localparam logic [7:0] W8   = 8'(GRID_W);
    localparam logic [7:0] H8   = 8'(GRID_H);
    localparam logic [7:0] MAXT = 8'(MAX_TRIES);

    state_t     state_q, state_d;
    logic [7:0] tries_q, tries_d;
    logic [6:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
    logic [6:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic       occ_req_q, occ_req_d;
    logic       food_valid_q, food_valid_d;
    logic       spawn_done_q, spawn_done_d;
    logic       spawn_fail_q, spawn_fail_d;
    logic       busy_q, busy_d;

`ifdef FOOD_SCAN_FALLBACK_EN
    logic [6:0] scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic       scan_last;
    assign scan_last = (scan_x_q == 7'(GRID_W - 1)) && (scan_y_q == 7'(GRID_H - 1));
`endif

    logic       in_range;
    logic [7:0] tries_inc;
    logic       exhausted;

    assign in_range  = ({1'b0, randX} < W8) && ({1'b0, randY} < H8);
    assign tries_inc = tries_q + 8'd1;
    // Evaluated on the miss that is being counted right now.
    assign exhausted = (tries_inc >= MAXT);

    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        occ_req_d    = 1'b0;
        spawn_done_d = 1'b0;
        spawn_fail_d = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (spawn_req) begin
                    state_d      = S_SAMPLE;
                    food_valid_d = 1'b0;
                    tries_d      = 8'd0;
`ifdef FOOD_SCAN_FALLBACK_EN
                    scan_x_d     = 7'd0;
                    scan_y_d     = 7'd0;
`endif
                end
            end
            S_SAMPLE: begin
                if (in_range) begin
                    occ_x_d   = randX;
                    occ_y_d   = randY;
                    occ_req_d = 1'b1;
                    state_d   = S_CHECK;
                end else begin
                    tries_d = tries_inc;
                    if (exhausted) state_d = S_EXH;
                end
            end
            S_CHECK: begin
                if (occ_ack) begin
                    if (!occ_hit) begin
                        state_d = S_DONE;
                    end else begin
                        tries_d = tries_inc;
                        state_d = exhausted ? S_EXH : S_SAMPLE;
                    end
                end
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            S_SCAN: begin
                occ_x_d   = scan_x_q;
                occ_y_d   = scan_y_q;
                occ_req_d = 1'b1;
                state_d   = S_SCAN_WAIT;
            end
            S_SCAN_WAIT: begin
                if (occ_ack) begin
                    if (!occ_hit) begin
                        state_d = S_DONE;
                    end else if (scan_last) begin
                        state_d = S_FAIL;
                    end else begin
                        // Raster order: x fastest, wrap to next row.
                        if (scan_x_q == 7'(GRID_W - 1)) begin
                            scan_x_d = 7'd0;
                            scan_y_d = scan_y_q + 7'd1;
                        end else begin
                            scan_x_d = scan_x_q + 7'd1;
                        end
                        state_d = S_SCAN;
                    end
                end
            end
`endif
            S_DONE: begin
                food_x_d     = occ_x_q;
                food_y_d     = occ_y_q;
                food_valid_d = 1'b1;
                spawn_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            S_FAIL: begin
                spawn_fail_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            tries_q      <= 8'd0;
            occ_x_q      <= 7'd0;
            occ_y_q      <= 7'd0;
            food_x_q     <= 7'd0;
            food_y_q     <= 7'd0;
            occ_req_q    <= 1'b0;
            food_valid_q <= 1'b0;
            spawn_done_q <= 1'b0;
            spawn_fail_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_x_q     <= 7'd0;
            scan_y_q     <= 7'd0;
`endif
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            occ_req_q    <= occ_req_d;
            food_valid_q <= food_valid_d;
            spawn_done_q <= spawn_done_d;
            spawn_fail_q <= spawn_fail_d;
            busy_q       <= busy_d;
`ifdef FOOD_SCAN_FALLBACK_EN
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
`endif
        end
    end

    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign occ_req    = occ_req_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign spawn_done = spawn_done_q;
    assign spawn_fail = spawn_fail_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner. A transaction-level model turns each spawn's
// candidate list and snake occupancy map into the expected query sequence
// and outcome; a single per-cycle compare step checks the DUT against it.
module tb_food_spawner;
    localparam int W  = 80;
    localparam int H  = 60;
    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] randX, randY;
    logic       spawn_req;
    logic [6:0] occ_x, occ_y;
    logic       occ_req;
    logic       occ_ack, occ_hit;
    logic [6:0] food_x, food_y;
    logic       food_valid, spawn_done, spawn_fail, busy;

    always #5 clk = ~clk;

    food_spawner #(.GRID_W(W), .GRID_H(H), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .randX(randX), .randY(randY),
        .spawn_req(spawn_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_req(occ_req), .occ_ack(occ_ack), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .spawn_done(spawn_done), .spawn_fail(spawn_fail), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Snake occupancy and per-spawn candidate stream.
    bit occ_map [0:127][0:127];
    int cand_x[$], cand_y[$];

    // Model expectations for the current spawn.
    int exp_qx[$], exp_qy[$];
    int exp_term, exp_fx, exp_fy;

    // Observable model state.
    int m_busy, m_fv, m_fx, m_fy;
    int outst, due, rd, sp_nreq, term_seen;
    int tcyc, acc_t, req1_t, term_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    function automatic void clear_map();
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++)
                occ_map[i][j] = 1'b0;
    endfunction

    // Spec rules: in-range candidates are queried in order; each off-grid
    // candidate or occupied answer costs a try; MT tries exhaust the search.
    function automatic void build_model();
        int tries, n, x, y;
        exp_qx.delete(); exp_qy.delete();
        tries = 0; n = 0;
        while (tries < MT) begin
            x = (n < cand_x.size()) ? cand_x[n] : 127;
            y = (n < cand_y.size()) ? cand_y[n] : 127;
            n++;
            if (x < W && y < H) begin
                exp_qx.push_back(x); exp_qy.push_back(y);
                if (!occ_map[x][y]) begin
                    exp_term = 1; exp_fx = x; exp_fy = y;
                    return;
                end
            end
            tries++;
        end
`ifdef FOOD_SCAN_FALLBACK_EN
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                exp_qx.push_back(xx); exp_qy.push_back(yy);
                if (!occ_map[xx][yy]) begin
                    exp_term = 1; exp_fx = xx; exp_fy = yy;
                    return;
                end
            end
`endif
        exp_term = 2;
    endfunction

    task automatic monitor();
        int exp_d, exp_f;
        tcyc++;
        if (spawn_req && rst && m_busy == 0) begin
            m_busy = 1; m_fv = 0; rd = 0; outst = 0; due = 0; sp_nreq = 0;
            acc_t = tcyc;
        end
        exp_d = (due != 0 && exp_term == 1) ? 1 : 0;
        exp_f = (due != 0 && exp_term == 2) ? 1 : 0;
        chk("spawn_done", spawn_done, exp_d);
        chk("spawn_fail", spawn_fail, exp_f);
        if (due != 0) begin
            m_busy = 0; term_seen = 1; term_t = tcyc; due = 0;
            if (exp_d != 0) begin m_fx = exp_fx; m_fy = exp_fy; m_fv = 1; end
        end
        if (occ_ack && outst != 0) begin
            outst = 0;
            if (rd == exp_qx.size()) due = 1;
        end
        if (occ_req) begin
            if (outst != 0 || rd >= exp_qx.size()) begin
                n_cmp++; n_err++;
                $display("FAIL occ_req: unexpected query at (%0d,%0d), want none (cycle %0d)",
                         occ_x, occ_y, tcyc);
            end else begin
                chk("occ_x", occ_x, exp_qx[rd]);
                chk("occ_y", occ_y, exp_qy[rd]);
                if (sp_nreq == 0) req1_t = tcyc;
                rd++; sp_nreq++; outst = 1;
            end
        end else if (outst != 0) begin
            chk("occ_x_hold", occ_x, exp_qx[rd-1]);
            chk("occ_y_hold", occ_y, exp_qy[rd-1]);
        end
        chk("busy", busy, m_busy);
        chk("food_valid", food_valid, m_fv);
        chk("food_x", food_x, m_fx);
        chk("food_y", food_y, m_fy);
    endtask

    // One clock: compare after the rising edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk); #1;
        monitor();
        @(negedge clk);
    endtask

    task automatic present(inout int ci);
        randX = (ci < cand_x.size()) ? 7'(cand_x[ci]) : 7'd127;
        randY = (ci < cand_y.size()) ? 7'(cand_y[ci]) : 7'd127;
        ci++;
    endtask

    // Runs one spawn: raises spawn_req, feeds candidates each sampling
    // cycle, answers queries from the occupancy map after dly cycles.
    task automatic run_spawn(input int dly, input bit dup_req, input int rst_at);
        int ci, wait_cnt, cyc;
        build_model();
        ci = 0; wait_cnt = 0; cyc = 0; term_seen = 0;
        spawn_req = 1'b1;
        while (term_seen == 0 && cyc < 400) begin
            cycle(); cyc++;
            if (term_seen != 0) break;
            spawn_req = 1'b0;
            if (rst_at != 0 && cyc == rst_at) begin
                rst = 1'b0; #1;
                chk("rst_occ_req", occ_req, 0);
                chk("rst_busy", busy, 0);
                chk("rst_food_valid", food_valid, 0);
                chk("rst_food_x", food_x, 0);
                m_busy = 0; m_fv = 0; m_fx = 0; m_fy = 0; outst = 0; due = 0;
                cycle();
                rst = 1'b1; occ_ack = 1'b1; occ_hit = 1'b0;  // late answer
                cycle();
                occ_ack = 1'b0;
                term_seen = 1;
                break;
            end
            if (dup_req && cyc == 3) spawn_req = 1'b1;
            if (occ_ack) begin
                occ_ack = 1'b0;
                present(ci);
            end else if (outst != 0) begin
                if (wait_cnt >= dly) begin
                    occ_ack = 1'b1;
                    occ_hit = occ_map[occ_x][occ_y];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                present(ci);
            end
        end
        if (term_seen == 0) begin
            n_cmp++; n_err++;
            $display("FAIL spawn_timeout: no completion after %0d cycles, want completion", cyc);
        end
        spawn_req = 1'b0; occ_ack = 1'b0;
        // Idle tail with a stray ack that must be ignored.
        cycle();
        occ_ack = 1'b1; occ_hit = 1'b0;
        cycle();
        occ_ack = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic set_cands(input int xs[$], input int ys[$]);
        cand_x = xs; cand_y = ys;
    endtask

    initial begin
        rst = 1'b0; spawn_req = 1'b0; randX = 7'd127; randY = 7'd127;
        occ_ack = 1'b0; occ_hit = 1'b0;
        m_busy = 0; m_fv = 0; m_fx = 0; m_fy = 0;
        outst = 0; due = 0; rd = 0; sp_nreq = 0; term_seen = 0;
        tcyc = 0; acc_t = 0; req1_t = 0; term_t = 0; exp_term = 0;
        exp_fx = 0; exp_fy = 0;
        clear_map();
        repeat (2) cycle();
        chk("reset_occ_x", occ_x, 0);
        chk("reset_occ_y", occ_y, 0);
        chk("reset_occ_req", occ_req, 0);
        chk("reset_spawn_done", spawn_done, 0);
        chk("reset_spawn_fail", spawn_fail, 0);
        rst = 1'b1;
        cycle();

        // Basic best-case spawn.
        set_cands('{10}, '{20});
        run_spawn(0, 1'b0, 0);
        chk("basic_food_x", food_x, 10);
        chk("basic_food_y", food_y, 20);
        chk("basic_food_valid", food_valid, 1);
        chk("basic_lat_req", req1_t - acc_t, 1);
        chk("basic_lat_done", term_t - acc_t, 3);

        // Off-grid x rejected three times.
        set_cands('{100, 100, 100, 5}, '{5, 5, 5, 5});
        run_spawn(1, 1'b0, 0);
        chk("oor_nreq", sp_nreq, 1);
        chk("oor_food_x", food_x, 5);
        chk("oor_food_y", food_y, 5);

        // Grid edges: 80/60 rejected, 79/59 accepted.
        set_cands('{80, 0, 127, 79}, '{0, 60, 59, 59});
        run_spawn(0, 1'b0, 0);
        chk("edge_nreq", sp_nreq, 1);
        chk("edge_food_x", food_x, 79);
        chk("edge_food_y", food_y, 59);

        // Occupied retry, with a spawn_req dropped while busy.
        occ_map[7][7] = 1'b1;
        set_cands('{7, 8}, '{7, 9});
        run_spawn(2, 1'b1, 0);
        chk("retry_nreq", sp_nreq, 2);
        chk("retry_food_x", food_x, 8);
        chk("retry_food_y", food_y, 9);

        // Exhaustion: every random candidate is occupied.
        clear_map();
        occ_map[1][1] = 1'b1; occ_map[2][2] = 1'b1;
        occ_map[3][3] = 1'b1; occ_map[4][4] = 1'b1;
        occ_map[0][0] = 1'b1; occ_map[1][0] = 1'b1;
        set_cands('{1, 2, 3, 4}, '{1, 2, 3, 4});
        run_spawn(0, 1'b0, 0);
`ifdef FOOD_SCAN_FALLBACK_EN
        chk("scan_nreq", sp_nreq, 7);
        chk("scan_food_x", food_x, 2);
        chk("scan_food_y", food_y, 0);
        chk("scan_food_valid", food_valid, 1);
`else
        chk("exh_nreq", sp_nreq, 4);
        chk("exh_food_valid", food_valid, 0);
        chk("exh_food_x", food_x, 8);
        chk("exh_food_y", food_y, 9);
`endif

        // Reset while the query is pending; late ack must be ignored.
        clear_map();
        set_cands('{30}, '{40});
        run_spawn(20, 1'b0, 2);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_food_x", food_x, 0);

        // Recovery after reset.
        set_cands('{3}, '{4});
        run_spawn(0, 1'b0, 0);
        chk("recover_food_x", food_x, 3);
        chk("recover_food_y", food_y, 4);
        chk("recover_food_valid", food_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
